// File: rtl/hdmi_line_fetch.sv
// Line fetcher: turns go_fill_fifo into IPIF burst reads and buffers the words in a show-ahead pixel FIFO.
// Optional line counter enabled by defining HDMI_FETCH_STATS_EN.
module hdmi_line_fetch #(
  parameter int BURST_BEATS = 16,
  parameter int FIFO_DEPTH  = 64
) (
  input  logic                         Bus2IP_Clk,
  input  logic                         Bus2IP_Resetn,
  input  logic                         go_fill_fifo,
  input  logic [31:0]                  ddr_addr_to_read,
  input  logic [15:0]                  line_bytes,
  output logic                         IP2Bus_MstRd_Req,
  output logic [31:0]                  IP2Bus_Mst_Addr,
  output logic [11:0]                  IP2Bus_Mst_Length,
  output logic                         IP2Bus_Mst_Type,
  input  logic                         Bus2IP_Mst_CmdAck,
  input  logic                         Bus2IP_Mst_Cmplt,
  input  logic                         Bus2IP_Mst_Error,
  input  logic [31:0]                  Bus2IP_MstRd_d,
  input  logic                         Bus2IP_MstRd_src_rdy_n,
  output logic                         IP2Bus_MstRd_dst_rdy_n,
  input  logic                         read_fifo,
  output logic [31:0]                  color,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
  output logic                         busy,
  output logic                         err_sticky,
  output logic                         ovr_sticky,
  output logic                         udf_sticky,
  output logic [15:0]                  line_count
);

  localparam int AW          = $clog2(FIFO_DEPTH);
  localparam int BURST_BYTES = BURST_BEATS * 4;

  typedef enum logic [1:0] {IDLE, WAIT_SPACE, REQ, DATA} state_t;

  state_t      state_q, state_d;
  logic        start;
  logic [31:0] addr_q;
  logic [15:0] rem_q;
  logic [11:0] len_q;
  logic [11:0] burst_len;
  logic        burst_done;
  logic        last_burst;

  logic [31:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic [AW:0] level;
  logic        empty, full, push, pop;

  assign burst_len  = (rem_q < 16'(BURST_BYTES)) ? rem_q[11:0] : 12'(BURST_BYTES);
  assign burst_done = (state_q == DATA) && Bus2IP_Mst_Cmplt;
  assign last_burst = (rem_q == {4'b0, len_q});

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    case (state_q)
      IDLE: begin
        if (go_fill_fifo && (line_bytes[15:2] != '0)) begin
          state_d = WAIT_SPACE;
          start   = 1'b1;
        end
      end
      // A whole burst of space is reserved up front so DATA never stalls
      WAIT_SPACE: begin
        if (level <= (AW+1)'(FIFO_DEPTH - BURST_BEATS)) state_d = REQ;
      end
      REQ: begin
        if (Bus2IP_Mst_CmdAck) state_d = DATA;
      end
      DATA: begin
        if (Bus2IP_Mst_Cmplt) begin
          if (Bus2IP_Mst_Error || last_burst) state_d = IDLE;
          else                                state_d = WAIT_SPACE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
    if (!Bus2IP_Resetn) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      if (start) begin
        addr_q <= ddr_addr_to_read;
        rem_q  <= line_bytes & 16'hFFFC;
      end
      if ((state_q == WAIT_SPACE) && (state_d == REQ)) len_q <= burst_len;
      if (burst_done) begin
        addr_q <= addr_q + {20'b0, len_q};
        rem_q  <= rem_q - {4'b0, len_q};
      end
    end
  end

  assign IP2Bus_MstRd_Req       = (state_q == REQ);
  assign IP2Bus_Mst_Addr        = addr_q;
  assign IP2Bus_Mst_Length      = len_q;
  assign IP2Bus_Mst_Type        = 1'b1;
  assign IP2Bus_MstRd_dst_rdy_n = (state_q != DATA);
  assign busy                   = (state_q != IDLE);

  // Pixel FIFO: extra pointer MSB distinguishes full from empty
  assign level = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push  = (state_q == DATA) && !Bus2IP_MstRd_src_rdy_n;
  assign pop   = read_fifo && !empty;

  always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
    if (!Bus2IP_Resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge Bus2IP_Clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= Bus2IP_MstRd_d;
  end

  assign color      = empty ? 32'h0 : mem[rd_ptr[AW-1:0]];
  assign fifo_level = level;

  always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
    if (!Bus2IP_Resetn) begin
      err_sticky <= 1'b0;
      ovr_sticky <= 1'b0;
      udf_sticky <= 1'b0;
    end else begin
      if (burst_done && Bus2IP_Mst_Error)        err_sticky <= 1'b1;
      if (go_fill_fifo && (state_q != IDLE))     ovr_sticky <= 1'b1;
      if (read_fifo && empty)                    udf_sticky <= 1'b1;
    end
  end

`ifdef HDMI_FETCH_STATS_EN
  logic [15:0] line_cnt_q;

  always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
    if (!Bus2IP_Resetn)                                      line_cnt_q <= '0;
    else if (burst_done && !Bus2IP_Mst_Error && last_burst)  line_cnt_q <= line_cnt_q + 16'd1;
  end

  assign line_count = line_cnt_q;
`else
  assign line_count = 16'h0;
`endif

  a_no_push_when_full: assert property (@(posedge Bus2IP_Clk) disable iff (!Bus2IP_Resetn)
    !(push && full));

endmodule

// File: tb/tb_hdmi_line_fetch.sv
// Scoreboard bench for hdmi_line_fetch: a bus responder queues the data it returns, a drainer pops and compares.
module tb_hdmi_line_fetch;

  localparam int BB = 64;  // bytes per full burst with the default BURST_BEATS

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        go = 1'b0;
  logic [31:0] ddr_addr = '0;
  logic [15:0] lbytes = '0;
  logic        req;
  logic [31:0] maddr;
  logic [11:0] mlen;
  logic        mtype;
  logic        cmdack = 1'b0;
  logic        cmplt = 1'b0;
  logic        merr = 1'b0;
  logic [31:0] rd_d = '0;
  logic        src_rdy_n = 1'b1;
  logic        dst_rdy_n;
  logic        read_fifo = 1'b0;
  logic [31:0] color;
  logic [6:0]  level;
  logic        busy, err_s, ovr_s, udf_s;
  logic [15:0] line_count;

  int checks = 0;
  int failures = 0;
  int lines_ok = 0;
  logic [31:0] exp_q[$];
  logic [43:0] req_q[$];

  always #5 clk = ~clk;

  hdmi_line_fetch dut (
    .Bus2IP_Clk(clk), .Bus2IP_Resetn(rst_n), .go_fill_fifo(go),
    .ddr_addr_to_read(ddr_addr), .line_bytes(lbytes),
    .IP2Bus_MstRd_Req(req), .IP2Bus_Mst_Addr(maddr), .IP2Bus_Mst_Length(mlen),
    .IP2Bus_Mst_Type(mtype), .Bus2IP_Mst_CmdAck(cmdack), .Bus2IP_Mst_Cmplt(cmplt),
    .Bus2IP_Mst_Error(merr), .Bus2IP_MstRd_d(rd_d), .Bus2IP_MstRd_src_rdy_n(src_rdy_n),
    .IP2Bus_MstRd_dst_rdy_n(dst_rdy_n), .read_fifo(read_fifo), .color(color),
    .fifo_level(level), .busy(busy), .err_sticky(err_s), .ovr_sticky(ovr_s),
    .udf_sticky(udf_s), .line_count(line_count)
  );

  function automatic logic [15:0] exp_lines();
`ifdef HDMI_FETCH_STATS_EN
    return 16'(lines_ok);
`else
    return 16'h0;
`endif
  endfunction

  task automatic plan_line(input logic [31:0] a, input logic [15:0] lb);
    logic [15:0] rem;
    logic [11:0] l;
    rem = lb & 16'hFFFC;
    while (rem != 0) begin
      l = (rem < 16'(BB)) ? rem[11:0] : 12'(BB);
      req_q.push_back({a, l});
      a = a + {20'b0, l};
      rem = rem - {4'b0, l};
    end
  endtask

  task automatic pulse_go(input logic [31:0] a, input logic [15:0] lb);
    go = 1'b1; ddr_addr = a; lbytes = lb;
    @(negedge clk);
    go = 1'b0;
  endtask

  task automatic serve_burst(input bit err);
    int t = 0;
    logic [43:0] e;
    logic [31:0] w;
    while (req !== 1'b1 && t < 300) begin @(negedge clk); t++; end
    checks++;
    if (req !== 1'b1) begin
      failures++;
      $display("FAIL req_timeout: req=%b after %0d cycles, required 1", req, t);
      return;
    end
    if (req_q.size() == 0) e = '0;
    else e = req_q.pop_front();
    if ({maddr, mlen} !== e)
      begin failures++; $display("FAIL req_cmd: addr=%h len=%0d, required addr=%h len=%0d", maddr, mlen, e[43:12], e[11:0]); end
    @(negedge clk);
    checks++;
    if (req !== 1'b1 || {maddr, mlen} !== e)
      begin failures++; $display("FAIL req_hold: req=%b addr=%h len=%0d, required held", req, maddr, mlen); end
    cmdack = 1'b1;
    @(negedge clk);
    cmdack = 1'b0;
    checks++;
    if (req !== 1'b0 || dst_rdy_n !== 1'b0)
      begin failures++; $display("FAIL data_phase: req=%b dst_rdy_n=%b, required 0/0", req, dst_rdy_n); end
    for (int i = 0; i < int'(e[11:0]) / 4; i++) begin
      w = $urandom;
      rd_d = w; src_rdy_n = 1'b0;
      exp_q.push_back(w);
      @(negedge clk);
    end
    src_rdy_n = 1'b1;
    cmplt = 1'b1; merr = err;
    @(negedge clk);
    cmplt = 1'b0; merr = 1'b0;
  endtask

  task automatic drain(input int n, input int budget);
    int got = 0;
    int t = 0;
    logic [31:0] e;
    while (got < n && t < budget) begin
      if (level != 0) begin
        checks++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_0000;
        if (color !== e)
          begin failures++; $display("FAIL color[%0d]: got %h, required %h", got, color, e); end
        read_fifo = 1'b1;
        got++;
      end else read_fifo = 1'b0;
      @(negedge clk);
      t++;
    end
    read_fifo = 1'b0;
    checks++;
    if (got != n) begin failures++; $display("FAIL drain_timeout: popped %0d, required %0d", got, n); end
  endtask

  task automatic no_req_for(input int n, input string tag);
    int seen = 0;
    for (int i = 0; i < n; i++) begin
      if (req === 1'b1) seen++;
      @(negedge clk);
    end
    checks++;
    if (seen != 0) begin failures++; $display("FAIL %s: req high %0d cycles, required 0", tag, seen); end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({req, maddr, mlen, mtype, dst_rdy_n} !== {1'b0, 32'h0, 12'h0, 1'b1, 1'b1})
      begin failures++; $display("FAIL reset_bus: req=%b addr=%h len=%h type=%b dst=%b, required 0/0/0/1/1", req, maddr, mlen, mtype, dst_rdy_n); end
    checks++;
    if ({color, level, busy, err_s, ovr_s, udf_s, line_count} !== '0)
      begin failures++; $display("FAIL reset_status: color=%h level=%0d busy=%b err=%b ovr=%b udf=%b lc=%0d, required all 0", color, level, busy, err_s, ovr_s, udf_s, line_count); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_full_line();
    plan_line(32'hA800_0000, 16'd5120);
    pulse_go(32'hA800_0000, 16'd5120);
    fork
      begin
        for (int b = 0; b < 80; b++) begin
          serve_burst(1'b0);
          if (b < 79) begin
            checks++;
            if (busy !== 1'b1) begin failures++; $display("FAIL busy_mid[%0d]: got %b, required 1", b, busy); end
          end
        end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL busy_end: got %b, required 0", busy); end
      end
      drain(1280, 4000);
    join
    lines_ok++;
    checks++;
    if (line_count !== exp_lines())
      begin failures++; $display("FAIL line_count_t1: got %0d, required %0d", line_count, exp_lines()); end
  endtask

  task automatic test_short_tail();
    plan_line(32'h1000_0040, 16'd100);
    pulse_go(32'h1000_0040, 16'd100);
    serve_burst(1'b0);
    serve_burst(1'b0);
    checks++;
    if (level !== 7'd25 || busy !== 1'b0)
      begin failures++; $display("FAIL short_tail: level=%0d busy=%b, required 25/0", level, busy); end
    lines_ok++;
    drain(25, 100);
  endtask

  task automatic test_backpressure();
    plan_line(32'h2000_0000, 16'd320);
    pulse_go(32'h2000_0000, 16'd320);
    for (int b = 0; b < 4; b++) serve_burst(1'b0);
    no_req_for(30, "wait_space_hold");
    checks++;
    if (level !== 7'd64 || busy !== 1'b1)
      begin failures++; $display("FAIL full_hold: level=%0d busy=%b, required 64/1", level, busy); end
    drain(16, 100);
    serve_burst(1'b0);
    checks++;
    if (level !== 7'd64 || busy !== 1'b0)
      begin failures++; $display("FAIL fifth_burst: level=%0d busy=%b, required 64/0", level, busy); end
    lines_ok++;
    drain(64, 200);
  endtask

  task automatic test_bus_error();
    plan_line(32'h3000_0100, 16'd256);
    pulse_go(32'h3000_0100, 16'd256);
    serve_burst(1'b0);
    serve_burst(1'b1);
    checks++;
    if (err_s !== 1'b1 || busy !== 1'b0 || level !== 7'd32)
      begin failures++; $display("FAIL bus_error: err=%b busy=%b level=%0d, required 1/0/32", err_s, busy, level); end
    no_req_for(20, "after_error");
    req_q.delete();
    drain(32, 100);
    checks++;
    if (line_count !== exp_lines())
      begin failures++; $display("FAIL line_count_err: got %0d, required %0d", line_count, exp_lines()); end
  endtask

  task automatic test_underflow_overrun();
    checks++;
    if (udf_s !== 1'b0 || ovr_s !== 1'b0)
      begin failures++; $display("FAIL sticky_pre: udf=%b ovr=%b, required 0/0", udf_s, ovr_s); end
    read_fifo = 1'b1;
    @(negedge clk);
    read_fifo = 1'b0;
    checks++;
    if (udf_s !== 1'b1 || color !== 32'h0 || level !== 7'd0)
      begin failures++; $display("FAIL underflow: udf=%b color=%h level=%0d, required 1/0/0", udf_s, color, level); end
    pulse_go(32'h4000_0000, 16'd3);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL zero_len_go: busy=%b, required 0", busy); end
    no_req_for(5, "zero_len_req");
    plan_line(32'h4000_0000, 16'd64);
    pulse_go(32'h4000_0000, 16'd64);
    pulse_go(32'h5000_0000, 16'd64);
    checks++;
    if (ovr_s !== 1'b1) begin failures++; $display("FAIL overrun: ovr=%b, required 1", ovr_s); end
    serve_burst(1'b0);
    lines_ok++;
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL ovr_busy: busy=%b, required 0", busy); end
    no_req_for(20, "ovr_extra_req");
    drain(16, 100);
  endtask

  task automatic test_async_reset();
    int t = 0;
    plan_line(32'h6000_0000, 16'd64);
    pulse_go(32'h6000_0000, 16'd64);
    while (req !== 1'b1 && t < 100) begin @(negedge clk); t++; end
    cmdack = 1'b1;
    @(negedge clk);
    cmdack = 1'b0;
    for (int i = 0; i < 3; i++) begin rd_d = 32'hCAFE_0000 + i; src_rdy_n = 1'b0; @(negedge clk); end
    checks++;
    if (level !== 7'd3 || busy !== 1'b1)
      begin failures++; $display("FAIL pre_reset: level=%0d busy=%b, required 3/1", level, busy); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({req, busy, level, dst_rdy_n} !== {1'b0, 1'b0, 7'd0, 1'b1})
      begin failures++; $display("FAIL async_reset: req=%b busy=%b level=%0d dst=%b, required 0/0/0/1", req, busy, level, dst_rdy_n); end
    checks++;
    if ({err_s, ovr_s, udf_s, line_count, color} !== '0)
      begin failures++; $display("FAIL reset_sticky: err=%b ovr=%b udf=%b lc=%0d color=%h, required 0", err_s, ovr_s, udf_s, line_count, color); end
    src_rdy_n = 1'b1;
    exp_q.delete();
    req_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    no_req_for(10, "post_reset_req");
  endtask

  initial begin
    test_reset();
    test_full_line();
    test_short_tail();
    test_backpressure();
    test_bus_error();
    test_underflow_overrun();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
